// File: rtl/load_store_unit.sv
// RV32 load/store unit: classifies one request at a time, drives a word-addressed
// memory port with byte-lane mask and replicated store data, returns extended load data.
module load_store_unit #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_misaligned,
  output logic        resp_fault,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_mask,
  output logic        mem_enable,
  output logic        mem_cmd,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_load_data,
  input  logic        mem_valid
);
  localparam logic MEM_CMD_READ  = 1'b0;
  localparam logic MEM_CMD_WRITE = 1'b1;
  localparam int   CW = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  state_e        state_q, state_d;
  logic          write_q, write_d;
  logic [2:0]    funct3_q, funct3_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          mis_q, mis_d;
  logic          fault_q, fault_d;

  logic          req_illegal, req_misaligned;
  logic [3:0]    lane_mask;
  logic [31:0]   lane_wdata, load_shift, load_ext;

  // Illegal encodings win over misalignment so a bad funct3 never looks like an alignment trap.
  always_comb begin
    req_illegal = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) || (req_funct3 == 3'b111) ||
                  (req_write && req_funct3[2]);
    req_misaligned = 1'b0;
    case (req_funct3[1:0])
      2'b01:   req_misaligned = req_addr[0];
      2'b10:   req_misaligned = |req_addr[1:0];
      default: req_misaligned = 1'b0;
    endcase
  end

  always_comb begin
    lane_mask  = 4'b0000;
    lane_wdata = wdata_q;
    load_shift = mem_load_data;
    load_ext   = mem_load_data;
    case (funct3_q[1:0])
      2'b00: begin
        lane_mask  = 4'b0001 << addr_q[1:0];
        lane_wdata = {4{wdata_q[7:0]}};
        load_shift = mem_load_data >> {addr_q[1:0], 3'b000};
        load_ext   = funct3_q[2] ? {24'b0, load_shift[7:0]} : {{24{load_shift[7]}}, load_shift[7:0]};
      end
      2'b01: begin
        lane_mask  = addr_q[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{wdata_q[15:0]}};
        load_shift = mem_load_data >> {addr_q[1], 4'b0000};
        load_ext   = funct3_q[2] ? {16'b0, load_shift[15:0]} : {{16{load_shift[15]}}, load_shift[15:0]};
      end
      2'b10: begin
        lane_mask  = 4'b1111;
        lane_wdata = wdata_q;
        load_ext   = mem_load_data;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    write_d  = write_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    mis_d    = mis_q;
    fault_d  = fault_q;
    case (state_q)
      IDLE: if (req_valid) begin
        write_d  = req_write;
        funct3_d = req_funct3;
        addr_d   = req_addr;
        wdata_d  = req_wdata;
        cnt_d    = '0;
        rdata_d  = '0;
        mis_d    = 1'b0;
        fault_d  = 1'b0;
        if (req_illegal) begin
          fault_d = 1'b1;
          state_d = RESP;
        end else if (req_misaligned) begin
          mis_d   = 1'b1;
          state_d = RESP;
        end else begin
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (write_q) begin
          state_d = RESP;
        end else if (mem_valid) begin
          rdata_d = load_ext;
          state_d = RESP;
        end else if (cnt_q == CW'(MEM_TIMEOUT)) begin
          fault_d = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      write_q  <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      rdata_q  <= '0;
      mis_q    <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      mis_q    <= mis_d;
      fault_q  <= fault_d;
    end
  end

  // Outputs decode straight from the async-reset state so reset silences them immediately.
  always_comb begin
    req_ready       = (state_q == IDLE);
    mem_enable      = (state_q == ACCESS);
    mem_addr        = mem_enable ? {addr_q[31:2], 2'b00} : 32'b0;
    mem_mask        = mem_enable ? lane_mask : 4'b0000;
    mem_cmd         = mem_enable ? (write_q ? MEM_CMD_WRITE : MEM_CMD_READ) : 1'b0;
    mem_write_data  = mem_enable ? lane_wdata : 32'b0;
    resp_valid      = (state_q == RESP);
    resp_rdata      = resp_valid ? rdata_q : 32'b0;
    resp_misaligned = resp_valid & mis_q;
    resp_fault      = resp_valid & fault_q;
  end
endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit against a byte-array memory model.
module tb_load_store_unit;
  localparam int MEM_TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_misaligned, resp_fault;
  logic [31:0] resp_rdata;
  logic [31:0] mem_addr, mem_write_data, mem_load_data;
  logic [3:0]  mem_mask;
  logic        mem_enable, mem_cmd, mem_valid;

  int total = 0;
  int bad   = 0;

  logic [7:0]  ref_mem [0:255];
  logic [31:0] dut_mem [0:63];

  load_store_unit #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_misaligned(resp_misaligned), .resp_fault(resp_fault),
    .mem_addr(mem_addr), .mem_mask(mem_mask), .mem_enable(mem_enable),
    .mem_cmd(mem_cmd), .mem_write_data(mem_write_data),
    .mem_load_data(mem_load_data), .mem_valid(mem_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic run_req(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input int dly, output logic [31:0] got);
    int sz, exp_cyc, cyc, bi;
    logic ill, mis, tmo;
    logic [31:0] exp_rd, exp_wd;
    logic [3:0] exp_m;
    sz  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    ill = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (wr && f3[2]);
    mis = !ill && ((a % sz) != 0);
    tmo = !ill && !mis && !wr && (dly > MEM_TIMEOUT);
    bi  = int'(a[7:0]);
    exp_m = 4'b0;
    for (int i = 0; i < sz; i++) exp_m = exp_m | 4'(1 << ((bi + i) % 4));
    exp_wd = (sz == 1) ? wd[7:0] * 32'h01010101 : (sz == 2) ? wd[15:0] * 32'h00010001 : wd;
    exp_rd = 32'b0;
    if (!wr && !ill && !mis && !tmo) begin
      for (int i = 0; i < sz; i++) exp_rd = exp_rd | (32'(ref_mem[bi + i]) << (8 * i));
      if (!f3[2] && sz == 1 && exp_rd[7])  exp_rd = exp_rd | 32'hFFFFFF00;
      if (!f3[2] && sz == 2 && exp_rd[15]) exp_rd = exp_rd | 32'hFFFF0000;
    end
    if (wr && !ill && !mis)
      for (int i = 0; i < sz; i++) ref_mem[bi + i] = wd[8*i +: 8];
    exp_cyc = wr ? 1 : tmo ? MEM_TIMEOUT + 1 : dly + 1;

    @(negedge clk);
    chk("ready_idle", req_ready, 1);
    req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0; req_wdata = $urandom; req_addr = $urandom;
    chk("ready_busy", req_ready, 0);
    if (ill || mis) begin
      chk("exc_valid", resp_valid, 1);
      chk("exc_mis", resp_misaligned, mis);
      chk("exc_fault", resp_fault, ill);
      chk("exc_rdata", resp_rdata, 0);
      chk("exc_no_en", mem_enable, 0);
      got = resp_rdata;
    end else begin
      cyc = 0;
      while (!resp_valid && cyc < 40) begin
        chk("acc_en", mem_enable, 1);
        if (cyc == 0) begin
          chk("acc_addr", mem_addr, {a[31:2], 2'b00});
          chk("acc_mask", mem_mask, exp_m);
          chk("acc_cmd", mem_cmd, wr);
          if (wr) chk("acc_wdata", mem_write_data, exp_wd);
        end
        if (wr && mem_enable && mem_cmd) begin
          for (int l = 0; l < 4; l++)
            if (mem_mask[l]) dut_mem[mem_addr[7:2]][8*l +: 8] = mem_write_data[8*l +: 8];
        end else if (!wr && cyc >= dly) begin
          mem_valid = 1'b1;
          mem_load_data = dut_mem[a[7:2]];
        end else begin
          mem_load_data = $urandom;
        end
        @(negedge clk);
        mem_valid = 1'b0;
        cyc++;
      end
      chk("latency", 32'(cyc), 32'(exp_cyc));
      chk("resp_valid", resp_valid, 1);
      chk("resp_rdata", resp_rdata, exp_rd);
      chk("resp_mis", resp_misaligned, 0);
      chk("resp_fault", resp_fault, tmo);
      chk("resp_no_en", mem_enable, 0);
      got = resp_rdata;
    end
    @(negedge clk);
    chk("pulse_end", resp_valid, 0);
    chk("ready_back", req_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] g;
    logic [2:0] f3;
    int r, dly;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'b0;
    req_addr = 32'b0; req_wdata = 32'b0; mem_load_data = 32'b0; mem_valid = 1'b0;
    for (int w = 0; w < 64; w++) begin
      dut_mem[w] = $urandom;
      for (int b = 0; b < 4; b++) ref_mem[4*w + b] = dut_mem[w][8*b +: 8];
    end
    @(negedge clk);
    chk("rst_ready", req_ready, 1);
    chk("rst_rvalid", resp_valid, 0);
    chk("rst_rdata", resp_rdata, 0);
    chk("rst_flags", {30'b0, resp_misaligned, resp_fault}, 0);
    chk("rst_mem", {mem_enable, mem_cmd, mem_mask}, 0);
    chk("rst_maddr", mem_addr, 0);
    chk("rst_mwdata", mem_write_data, 0);
    @(negedge clk);
    reset = 1'b0;

    run_req(1, 3'b010, 32'h100, 32'hDEADBEEF, 0, g);
    run_req(0, 3'b010, 32'h100, 32'h0, 0, g);
    chk("t1_lw", g, 32'hDEADBEEF);
    run_req(1, 3'b000, 32'h103, 32'h123456A5, 0, g);
    run_req(0, 3'b000, 32'h103, 32'h0, 0, g);
    chk("t2_lb", g, 32'hFFFFFFA5);
    run_req(0, 3'b100, 32'h103, 32'h0, 1, g);
    chk("t2_lbu", g, 32'h000000A5);
    run_req(1, 3'b001, 32'h102, 32'h00008001, 0, g);
    run_req(0, 3'b001, 32'h102, 32'h0, 0, g);
    chk("t3_lh", g, 32'hFFFF8001);
    run_req(0, 3'b101, 32'h102, 32'h0, 3, g);
    chk("t3_lhu", g, 32'h00008001);
    run_req(0, 3'b010, 32'h102, 32'h0, 0, g);
    run_req(1, 3'b001, 32'h101, 32'h5555, 0, g);
    run_req(1, 3'b100, 32'h100, 32'h77, 0, g);
    run_req(0, 3'b010, 32'h108, 32'h0, 100, g);
    chk("t5_tmo_rdata", g, 0);
    run_req(0, 3'b010, 32'h108, 32'h0, 15, g);
    run_req(0, 3'b010, 32'h108, 32'h0, 0, g);

    // Reset in the middle of an ACCESS cycle.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; req_addr = 32'h104;
    @(negedge clk);
    req_valid = 1'b0;
    chk("t6_en_before", mem_enable, 1);
    #2 reset = 1'b1;
    #1;
    chk("t6_en_async", mem_enable, 0);
    chk("t6_mem_async", {mem_cmd, mem_mask, mem_addr[7:0]}, 0);
    chk("t6_rv_async", resp_valid, 0);
    chk("t6_ready_async", req_ready, 1);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t6_no_resp", resp_valid, 0);
    end
    run_req(0, 3'b010, 32'h104, 32'h0, 0, g);

    for (int n = 0; n < 80; n++) begin
      r = $urandom_range(0, 15);
      case (r % 5)
        0: f3 = 3'b000;
        1: f3 = 3'b001;
        2: f3 = 3'b010;
        3: f3 = 3'b100;
        default: f3 = 3'b101;
      endcase
      if (r >= 13) f3 = 3'($urandom_range(0, 7));
      r = $urandom_range(0, 9);
      dly = (r < 6) ? $urandom_range(0, 2) : (r < 9) ? $urandom_range(0, 15) : 100;
      run_req(1'($urandom_range(0, 1)), f3, 32'h100 + $urandom_range(0, 63), $urandom, dly, g);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sits between the execute stage and the word-addressed data memory port. Accepts one RV32 load/store request at a time and checks alignment. Drives the memory's `addr`/`mask`/`enable`/`cmd`/`write_data` interface with a byte-lane mask and lane-replicated store data. Returns sign- or zero-extended load data, or an exception flag, on a one-cycle response pulse.

## Interface

Parameters:
- `MEM_TIMEOUT`, default 15: maximum ACCESS cycles to wait for `mem_valid` on a read before signalling a fault.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept; high only in IDLE.
- `req_write`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  size/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-aligned.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_rdata`  out  32  extended load data; 0 for stores and exceptions.
- `resp_misaligned`  out  1  alignment exception; valid with `resp_valid`.
- `resp_fault`  out  1  illegal funct3 or memory timeout; valid with `resp_valid`.
- `mem_addr`  out  32  word-aligned address, `{addr[31:2],2'b00}`.
- `mem_mask`  out  4  byte-lane enables; bit i = byte i.
- `mem_enable`  out  1  memory access strobe.
- `mem_cmd`  out  1  `MEM_CMD_READ` / `MEM_CMD_WRITE` encodings.
- `mem_write_data`  out  32  lane-replicated store data.
- `mem_load_data`  in  32  word from memory.
- `mem_valid`  in  1  `mem_load_data` is valid.

## Operation

- The FSM has three states: IDLE, ACCESS, RESP. Reset forces IDLE.
- **IDLE:** `req_ready`=1. On `req_valid`, latch write, funct3, addr and wdata, then classify the request:
  - **Illegal:** funct3 ∈ {011, 110, 111}, or a store with funct3 100/101. Go to RESP with `resp_fault`=1.
  - **Misaligned:** H/HU with addr[0]=1, or W with addr[1:0]≠0. Go to RESP with `resp_misaligned`=1. No memory access occurs.
  - **Otherwise:** go to ACCESS and clear the timeout counter.
- **ACCESS:** `mem_enable`=1 and `mem_addr`/`mem_mask`/`mem_cmd`/`mem_write_data` come from the latched request.
  - **Store:** exactly one ACCESS cycle, then RESP.
  - **Load:** on `mem_valid`, capture the extracted result, then RESP.
  - **Load timeout:** if `mem_valid` is still 0 when the counter reaches `MEM_TIMEOUT`, go to RESP with `resp_fault`=1 and `resp_rdata`=0.
- **RESP:** `resp_valid`=1 for one cycle, then IDLE. The response has no backpressure.
- **Mask:**
  - B/BU: `4'b0001 << addr[1:0]`.
  - H/HU: addr[1] ? 1100 : 0011.
  - W: 1111.
- **Store data:**
  - B: `{4{wdata[7:0]}}`.
  - H: `{2{wdata[15:0]}}`.
  - W: wdata unchanged.
- **Load extract:** shift `mem_load_data` right by 8·addr[1:0] (B) or 16·addr[1] (H).
  - B and H are sign-extended from bit 7 and bit 15 respectively.
  - BU and HU are zero-extended.
  - W is passed through.
- All `mem_*` outputs are 0 outside ACCESS.
- `resp_*` outputs are 0 outside RESP.
- **Async reset in any state:** state returns to IDLE immediately. All `mem_*` and `resp_*` outputs go to 0, and no partial response is emitted. The interrupted request is dropped; the requester must reissue it.

## Timing

- **Reset values:** `req_ready`=1 once in IDLE. `resp_valid`, `resp_rdata`, `resp_misaligned`, `resp_fault`, `mem_enable`, `mem_mask`, `mem_addr`, `mem_write_data` and `mem_cmd` are all 0.
- **Accepted request:** accepted at edge N. ACCESS runs in cycle N+1. For a store, or a load with `mem_valid` in the same cycle, `resp_valid` is high in cycle N+2.
- **Load with delayed valid:** each extra cycle of `mem_valid`=0 adds one cycle of latency. The worst case is `MEM_TIMEOUT`+1 ACCESS cycles.
- **Exception:** `resp_valid` is high in cycle N+1.
- **Back-to-back:** throughput is one request per 3 cycles. `req_ready` falls the cycle after acceptance and rises in the cycle after RESP.
- **Registered outputs:** `resp_rdata` is registered at the ACCESS→RESP edge and is stable throughout RESP.

## Test plan

1. SW 0xDEADBEEF @0x100, then LW @0x100.
   - The store drives `mem_mask`=1111.
   - The load returns `resp_rdata`=0xDEADBEEF two cycles after acceptance, with both exception flags 0.
2. SB wdata=0x1234_56A5 @0x103.
   - `mem_mask`=1000, `mem_write_data`=0xA5A5A5A5, `mem_addr`=0x100.
   - LB @0x103 then returns 0xFFFFFFA5; LBU @0x103 returns 0x000000A5.
3. SH 0x8001 @0x102.
   - `mem_mask`=1100, `mem_write_data`=0x80018001.
   - LH @0x102 returns 0xFFFF8001; LHU returns 0x00008001.
4. Misaligned and illegal requests:
   - LW @0x102: `resp_valid` and `resp_misaligned`=1 in cycle N+1, and `mem_enable` never rises.
   - SH @0x101: same response as LW @0x102.
   - Store with funct3=100: `resp_fault`=1.
5. Timeout: LW with `mem_valid` held 0 gives `resp_fault`=1 and `resp_rdata`=0 after 16 ACCESS cycles (`MEM_TIMEOUT`=15). A following LW with `mem_valid`=1 completes normally.
6. Reset mid-operation: assert `reset` mid-cycle during ACCESS.
   - `mem_enable` drops to 0 without waiting for a clock edge, and no `resp_valid` pulse appears.
   - After release, `req_ready`=1 and a new LW completes in 2 cycles.
